// File: rtl/uart_tx_ceas_pkg.sv
// Shared definitions for the clock's UART time reporter: ASCII constants,
// field limits, FSM state encodings and the digit conversion helpers.
package ceas_pkg;

    localparam int DEF_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [4:0] MAX_ORE    = 5'd23;
    localparam logic [5:0] MAX_MINUTE = 6'd59;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BYTE, S_NEXT, S_DONE} seq_state_e;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_e;

    // Hours to {tens, units} ASCII; tens found by threshold compare, no divider.
    function automatic logic [15:0] hour_ascii(input logic [4:0] h);
        logic [1:0] t;
        logic [4:0] u;
        t = 2'd0;
        u = h;
        if (h > MAX_ORE) return {ASCII_DASH, ASCII_DASH};
        if (h >= 5'd20)      begin t = 2'd2; u = h - 5'd20; end
        else if (h >= 5'd10) begin t = 2'd1; u = h - 5'd10; end
        return {ASCII_0 + {6'd0, t}, ASCII_0 + {3'd0, u}};
    endfunction

    // Minutes to {tens, units} ASCII via the 50/40/30/20/10 thresholds.
    function automatic logic [15:0] minute_ascii(input logic [5:0] m);
        logic [2:0] t;
        logic [5:0] u;
        t = 3'd0;
        u = m;
        if (m > MAX_MINUTE) return {ASCII_DASH, ASCII_DASH};
        if (m >= 6'd50)      begin t = 3'd5; u = m - 6'd50; end
        else if (m >= 6'd40) begin t = 3'd4; u = m - 6'd40; end
        else if (m >= 6'd30) begin t = 3'd3; u = m - 6'd30; end
        else if (m >= 6'd20) begin t = 3'd2; u = m - 6'd20; end
        else if (m >= 6'd10) begin t = 3'd1; u = m - 6'd10; end
        return {ASCII_0 + {5'd0, t}, ASCII_0 + {2'd0, u}};
    endfunction

endpackage

// File: rtl/uart_tx_ceas_if.sv
// Request/status bundle between the time counter side and the transmitter.
interface uart_tx_ceas_if;
    logic       send;
    logic [4:0] ore;
    logic [5:0] minute;
    logic       o_tx_serial;
    logic       busy;
    logic       done;

    modport master (output send, ore, minute, input  o_tx_serial, busy, done);
    modport slave  (input  send, ore, minute, output o_tx_serial, busy, done);
endinterface

// File: rtl/uart_tx_ceas_byte.sv
// uart_tx_byte: reusable 8N1 serialiser, LSB first, CLKS_PER_BIT cycles per bit.
// A start is taken only from IDLE; the line goes low on the following edge.
// busy drops in the last cycle of the stop bit, so a caller may register its
// next start then and the next start bit follows after one idle-high cycle.
// byte_done marks the last cycle of data bit 7 (only the stop bit remains),
// giving the caller the whole stop bit to prepare the next byte.
module uart_tx_byte
    import ceas_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       o_tx_serial,
    output logic       busy,
    output logic       byte_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    ser_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          bit_end;

    assign bit_end     = (cnt_q == CNT_LAST);
    assign o_tx_serial = tx_q;
    assign busy        = (state_q != IDLE) && !(state_q == STOP && bit_end);
    assign byte_done   = (state_q == DATA) && (bit_q == 3'd7) && bit_end;

    // Frame state machine: bit timer, bit index, shift register and line driver.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (start) begin
                        shift_q <= data;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else cnt_q <= cnt_q + CW'(1);
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else cnt_q <= cnt_q + CW'(1);
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else cnt_q <= cnt_q + CW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_ceas.sv
// uart_tx_ceas: on a send pulse snapshots hours/minutes and transmits "HH:MM"
// (plus CR LF when UART_TX_CRLF_EN is defined) as 8N1 frames.
// Send sampled at edge N: busy from N+1, first start bit from N+2.
// Inter-byte gap: exactly 1 idle-high cycle between a stop bit and the next
// start bit. done pulses (and busy falls) in the cycle after the last stop bit.
module uart_tx_ceas
    import ceas_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_ceas_if.slave     tx_if
);
`ifdef UART_TX_CRLF_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif

    seq_state_e  state_q;
    logic [2:0]  idx_q;
    logic [4:0]  ore_q;
    logic [5:0]  min_q;
    logic        start_q;
    logic [7:0]  data_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] hr_a;
    logic [15:0] mn_a;
    logic [7:0]  byte_sel;
    logic        ser_tx;
    logic        ser_busy;
    logic        ser_bdone;

    assign hr_a = hour_ascii(ore_q);
    assign mn_a = minute_ascii(min_q);

    // Message byte for the current index, from the snapshot fields.
    always_comb begin
        byte_sel = ASCII_COLON;
        case (idx_q)
            3'd0: byte_sel = hr_a[15:8];
            3'd1: byte_sel = hr_a[7:0];
            3'd2: byte_sel = ASCII_COLON;
            3'd3: byte_sel = mn_a[15:8];
            3'd4: byte_sel = mn_a[7:0];
`ifdef UART_TX_CRLF_EN
            3'd5: byte_sel = ASCII_CR;
            3'd6: byte_sel = ASCII_LF;
`endif
            default: byte_sel = ASCII_COLON;
        endcase
    end

    // Message sequencer: snapshot, per-byte handoff and completion pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ore_q   <= '0;
            min_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_if.send) begin
                        ore_q   <= tx_if.ore;
                        min_q   <= tx_if.minute;
                        idx_q   <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    busy_q <= 1'b1;
                    // Waits out the previous stop bit; issues the start in its last cycle.
                    if (!ser_busy) begin
                        data_q  <= byte_sel;
                        start_q <= 1'b1;
                        state_q <= S_BYTE;
                    end
                end
                S_BYTE: if (ser_bdone) state_q <= S_NEXT;
                S_NEXT: begin
                    if (idx_q == LAST_IDX) state_q <= S_DONE;
                    else begin
                        idx_q   <= idx_q + 3'd1;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    if (!ser_busy) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clock       (clock),
        .reset       (reset),
        .start       (start_q),
        .data        (data_q),
        .o_tx_serial (ser_tx),
        .busy        (ser_busy),
        .byte_done   (ser_bdone)
    );

    assign tx_if.o_tx_serial = ser_tx;
    assign tx_if.busy        = busy_q;
    assign tx_if.done        = done_q;
endmodule

// File: tb/tb_uart_tx_ceas.sv
// Bench for uart_tx_ceas (CLKS_PER_BIT = 4); honours UART_TX_CRLF_EN.
// Line is decoded like a UART receiver and compared to a digit model built
// with / and %.
module tb_uart_tx_ceas;
    localparam int C    = 4;
    localparam int MAXS = 400;
`ifdef UART_TX_CRLF_EN
    localparam int NB = 7;
`else
    localparam int NB = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       ln [MAXS];
    logic       bs [MAXS];
    logic       dn [MAXS];

    uart_tx_ceas_if bus ();

    uart_tx_ceas #(.CLKS_PER_BIT(C)) dut (
        .clock (clk),
        .reset (rst),
        .tx_if (bus)
    );

    always #5 clk = ~clk;

    // Reference message from the field values.
    function automatic void build_expected(input int h, input int m);
        exp_q.delete();
        if (h > 23) begin exp_q.push_back(8'h2D); exp_q.push_back(8'h2D); end
        else begin exp_q.push_back(8'(48 + h / 10)); exp_q.push_back(8'(48 + h % 10)); end
        exp_q.push_back(8'h3A);
        if (m > 59) begin exp_q.push_back(8'h2D); exp_q.push_back(8'h2D); end
        else begin exp_q.push_back(8'(48 + m / 10)); exp_q.push_back(8'(48 + m % 10)); end
`ifdef UART_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endfunction

    // Pulse send (caller sits at a negedge), record until done, decode and check.
    // disturb_at >= 0: at that sample, change the fields and pulse send again.
    task automatic xmit_and_check(input int h, input int m, input int disturb_at,
                                  input string tag, input bit hold);
        int n, done_idx, fb, fz, ferr, p, s, bcnt;
        logic [7:0] v;
        build_expected(h, m);
        bus.ore    = 5'(h);
        bus.minute = 6'(m);
        bus.send   = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        n = 0;
        done_idx = -1;
        while (n < MAXS) begin
            ln[n] = bus.o_tx_serial;
            bs[n] = bus.busy;
            dn[n] = bus.done;
            n++;
            if (dn[n-1]) begin done_idx = n - 1; break; end
            if (n - 1 == disturb_at) begin
                bus.ore    = 5'($urandom_range(0, 23));
                bus.minute = 6'($urandom_range(0, 59));
                bus.send   = 1'b1;
            end else bus.send = 1'b0;
            @(negedge clk);
        end
        bus.send = 1'b0;
        n_checks++;
        if (done_idx < 0) begin
            n_fail++;
            $display("FAIL %s timeout: done not seen in %0d cycles", tag, MAXS);
            return;
        end
        fb = -1; fz = -1; bcnt = 0;
        for (int i = 0; i <= done_idx; i++) begin
            if (bs[i] && fb < 0) fb = i;
            if (!ln[i] && fz < 0) fz = i;
            if (bs[i]) bcnt++;
        end
        n_checks++;
        if (fb !== 1) begin n_fail++; $display("FAIL %s busy_latency: got %0d expected 1", tag, fb); end
        n_checks++;
        if (fz !== 2) begin n_fail++; $display("FAIL %s start_latency: got %0d expected 2", tag, fz); end
        // UART-style decode at mid-bit.
        got_q.delete();
        ferr = 0;
        p = 0;
        while (p <= done_idx) begin
            if (!ln[p]) begin
                s = p + C / 2;
                if (s + 9 * C > done_idx) begin ferr++; break; end
                for (int k = 0; k < 8; k++) v[k] = ln[s + (k + 1) * C];
                if (!ln[s + 9 * C]) ferr++;
                got_q.push_back(v);
                p += 10 * C;
            end else p++;
        end
        n_checks++;
        if (got_q.size() != NB) begin
            n_fail++; $display("FAIL %s byte_count: got %0d expected %0d", tag, got_q.size(), NB);
        end
        for (int i = 0; i < NB && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL %s byte%0d: got %02h expected %02h", tag, i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ferr != 0) begin n_fail++; $display("FAIL %s framing: got %0d errors expected 0", tag, ferr); end
        n_checks++;
        if (bs[done_idx] !== 1'b0 || ln[done_idx] !== 1'b1) begin
            n_fail++; $display("FAIL %s done_cycle: busy=%b line=%b expected busy=0 line=1", tag, bs[done_idx], ln[done_idx]);
        end
        n_checks++;
        if (bcnt < NB * 10 * C || bcnt > NB * 10 * C + NB || bcnt != done_idx - 1) begin
            n_fail++; $display("FAIL %s busy_span: got %0d cycles (done at %0d) expected %0d..%0d contiguous",
                               tag, bcnt, done_idx, NB * 10 * C, NB * 10 * C + NB);
        end
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                n_checks++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.o_tx_serial !== 1'b1) begin
                    n_fail++; $display("FAIL %s after_done: done=%b busy=%b line=%b expected 0 0 1",
                                       tag, bus.done, bus.busy, bus.o_tx_serial);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.send = 1'b0; bus.ore = '0; bus.minute = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.o_tx_serial !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b expected 1", bus.o_tx_serial); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed();
        xmit_and_check(9, 5, -1, "t0905", 1'b1);
        xmit_and_check(23, 59, -1, "t2359", 1'b1);
        xmit_and_check(0, 0, -1, "t0000", 1'b1);
    endtask

    task automatic test_out_of_range();
        xmit_and_check(24, 0, -1, "oor_hour", 1'b1);
        xmit_and_check(0, 60, -1, "oor_min", 1'b1);
        xmit_and_check(31, 63, -1, "oor_both", 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            xmit_and_check(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), -1,
                           $sformatf("rand%0d", i), 1'b1);
        end
    endtask

    task automatic test_snapshot();
        int act;
        // Sample 100 lies inside the third byte's frame.
        xmit_and_check(12, 34, 100, "snapshot", 1'b1);
        act = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done || !bus.o_tx_serial) act++;
        end
        n_checks++;
        if (act != 0) begin n_fail++; $display("FAIL snapshot_no_second: got %0d active cycles expected 0", act); end
    endtask

    task automatic test_back_to_back();
        xmit_and_check(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), -1, "b2b_first", 1'b0);
        xmit_and_check(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), -1, "b2b_second", 1'b1);
    endtask

    task automatic test_reset_mid();
        int dcnt, act;
        bus.ore    = 5'($urandom_range(0, 23));
        bus.minute = 6'($urandom_range(0, 59));
        bus.send   = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        dcnt = 0;
        // Sample 55 is inside the second byte's data bits.
        for (int i = 0; i < 55; i++) begin
            if (bus.done) dcnt++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.o_tx_serial !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_state: line=%b busy=%b done=%b expected 1 0 0",
                               bus.o_tx_serial, bus.busy, bus.done);
        end
        act = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
            if (bus.busy || !bus.o_tx_serial) act++;
        end
        n_checks++;
        if (dcnt != 0 || act != 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: done=%0d active=%0d expected 0 0", dcnt, act);
        end
        xmit_and_check(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), -1, "after_reset", 1'b1);
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_out_of_range();
        test_random();
        test_snapshot();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_ceas.md
# uart_tx_ceas

UART transmitter that reports the clock's current time over a serial line, the outbound counterpart of the time-setting UART receiver. On a one-cycle `send` request it snapshots the hour/minute counter values and converts them to ASCII `HH:MM`, optionally followed by CR LF. It then serialises the bytes as 8N1 frames on `o_tx_serial`. It sits beside the time counter in the clock top level, driven by the counter outputs and a user or periodic trigger.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per UART bit (50 MHz / 9600 baud); legal range ≥ 2.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `send`  in  1  request pulse; sampled each cycle; acted on only when idle.
- `ore`  in  5  hours from the time counter, legal 0..23.
- `minute`  in  6  minutes from the time counter, legal 0..59.
- `o_tx_serial`  out  1  serial line; idles high.
- `busy`  out  1  high while a message is in flight.
- `done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Message bytes, in order:
  - hour tens digit
  - hour units digit
  - `:` (0x3A)
  - minute tens digit
  - minute units digit
  - 0x0D, 0x0A when CRLF is enabled.
- Digits are ASCII 0x30 + value.
- Tens are computed by comparison and subtraction; no divider.
  - Hours: ≥20 gives 2, ≥10 gives 1, otherwise 0.
  - Minutes: thresholds 50/40/30/20/10.
- Out-of-range field: `ore` > 23 sends both hour digits as `-` (0x2D); `minute` > 59 does the same for the minute digits. The other field is unaffected.
- Snapshot rule:
  - `ore` and `minute` are registered in the cycle `send` is accepted.
  - Later input changes do not affect the message in flight.
- `send` while `busy` is ignored; it is not queued.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Sequencer states: S_IDLE → S_LOAD → S_BYTE → S_NEXT → (S_LOAD or S_DONE) → S_IDLE.
  - S_LOAD selects the byte for the current index.
  - S_BYTE waits for the serialiser to finish the byte.
  - S_NEXT increments the index, or goes to S_DONE after the last byte.
- Serialiser states: IDLE, START, DATA (bit index 0..7), STOP.
- Reset at any point, including mid-byte:
  - Both FSMs return to idle and the byte index clears.
  - `o_tx_serial` = 1, `busy` = 0, `done` = 0 from the next edge.
  - No partial `done` is issued.

## Timing
- Reset values: `o_tx_serial` = 1, `busy` = 0, `done` = 0.
- Accepted `send` at edge N:
  - `busy` = 1 from edge N+1.
  - Start bit (`o_tx_serial` = 0) from edge N+2.
- Bytes are back-to-back: the next start bit begins exactly 1 cycle after the previous stop bit period ends (the S_NEXT/S_LOAD bookkeeping overlaps the stop bit). Inter-byte gap is 0 or 1 cycle, fixed for the design and documented in the RTL header.
- `done` pulses for exactly one cycle, in the cycle after the final stop bit period ends.
  - `busy` falls in that same cycle.
  - `o_tx_serial` remains high.
- A new `send` is accepted in the cycle `done` is high or any later cycle.
- Total message duration: 5×10×`CLKS_PER_BIT` cycles (7×10×`CLKS_PER_BIT` with CRLF), plus fixed overhead of ≤ 1 cycle per byte.
- Bit counter width: $clog2(`CLKS_PER_BIT`); it counts 0..`CLKS_PER_BIT`−1 and wraps.

## Configuration
- `UART_TX_CRLF_EN` defined:
  - 7-byte message ending in 0x0D 0x0A.
  - Byte index is 3 bits; last index is 6.
- Not defined:
  - 5-byte message `HH:MM`.
  - Last index is 4.
  - No CR/LF constants are referenced.

## Structure
- Shared package `ceas_pkg`:
  - ASCII constants `ASCII_0`, `ASCII_COLON`, `ASCII_DASH`, `ASCII_CR`, `ASCII_LF`.
  - Default `CLKS_PER_BIT`.
  - `MAX_ORE` = 23, `MAX_MINUTE` = 59.
  - Sequencer and serialiser state enums.
- Sub-module `uart_tx_byte`: 8N1 serialiser with `clock`, `reset`, `start`, `data[7:0]`, `o_tx_serial`, `busy`, `byte_done`. It is reusable by other transmitters.
- Top `uart_tx_ceas` contains the snapshot, BCD/ASCII conversion, byte mux and sequencer FSM.

## Test plan
- `CLKS_PER_BIT`=4, `ore`=9, `minute`=5, pulse `send` → line decodes 0x30 0x39 0x3A 0x30 0x35; `busy` spans the message; one `done` pulse.
- `ore`=23, `minute`=59 with `UART_TX_CRLF_EN` → 0x32 0x33 0x3A 0x35 0x39 0x0D 0x0A; total duration 70×4 cycles ± overhead.
- `ore`=24, `minute`=0 → 0x2D 0x2D 0x3A 0x30 0x30; `ore`=0, `minute`=60 → 0x30 0x30 0x3A 0x2D 0x2D.
- Change `ore`/`minute` and pulse `send` again during byte 2 → message unchanged, no second message, single `done`.
- Assert `reset` for 1 cycle during byte 1's data bits → `o_tx_serial` = 1 and `busy` = 0 at the next edge, no `done`; a subsequent `send` produces a full correct message.
